// File: rtl/latch_report_link_pkg.sv
// Shared constants and state encoding for the counter-to-host report link.
package latch_report_pkg;

  localparam logic [7:0] CMD_RST1 = 8'h00;
  localparam logic [7:0] CMD_RST2 = 8'h01;
  localparam logic [7:0] CMD_LAT1 = 8'h02;
  localparam logic [7:0] CMD_LAT2 = 8'h03;

  localparam logic [7:0] CHAN1_HDR = 8'h00;
  localparam logic [7:0] CHAN2_HDR = 8'h01;

  localparam int FRAME_BODY = 5;

  typedef enum logic [1:0] {IDLE, HDR, BODY} linkState_t;

  // Only the low byte of the high counter word is reported.
  function automatic logic [39:0] makeSnapshot(input logic [7:0] hi, input logic [31:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/latch_report_link_if.sv
// Byte-stream link between the report stage (master) and the USB/UART bridge (slave).
interface latch_report_link_if;

  logic [7:0] oTxData;
  logic       oTxValid;
  logic       iTxReady;
  logic [7:0] iRxData;
  logic       iRxValid;

  modport master (output oTxData, oTxValid, input iTxReady, iRxData, iRxValid);
  modport slave  (input oTxData, oTxValid, output iTxReady, iRxData, iRxValid);

endinterface

// File: rtl/latch_report_link_pulse_stretch.sv
// Stretches a one-cycle trigger into a pPULSE-cycle pulse; re-triggering restarts it.
module pulse_stretch #(
  parameter int pPULSE = 4
) (
  input  logic iCLK,
  input  logic iRSTn,
  input  logic iTrig,
  output logic oPulse
);

  localparam logic [7:0] LOAD = 8'(pPULSE);

  logic [7:0] count;

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      count <= 8'd0;
    end else if (iTrig) begin
      count <= LOAD;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign oPulse = (count != 8'd0);

endmodule

// File: rtl/latch_report_link.sv
// Frames latched counter values into 6-byte reports and decodes host command bytes into pulses.
module latch_report_link
  import latch_report_pkg::*;
#(
  parameter int pPULSE   = 4,
  parameter int pTIMEOUT = 0
) (
  input  logic                       iCLK,
  input  logic                       iRSTn,
  latch_report_link_if.master        link,
  input  logic [31:0]                i1COUNTER,
  input  logic [31:0]                i1COUNTERHi,
  input  logic                       iRdy1,
  input  logic [31:0]                i2COUNTER,
  input  logic [31:0]                i2COUNTERHi,
  input  logic                       iRdy2,
  output logic                       oResetLatch1,
  output logic                       oResetLatch2,
  output logic                       oLatch1,
  output logic                       oLatch2,
  output logic [7:0]                 oBadCmd
);

  localparam logic [2:0]  LAST_IDX = 3'(FRAME_BODY - 1);
  localparam logic        TMO_EN   = (pTIMEOUT > 0);
  localparam logic [31:0] TMO_LAST = (pTIMEOUT > 0) ? 32'(pTIMEOUT - 1) : 32'd0;

  linkState_t  state;
  logic        chan;
  logic [39:0] snap;
  logic [2:0]  idx;
  logic [1:0]  sent;
  logic [1:0]  rdy;
  logic [1:0]  tmo;
  logic [31:0] timer [2];
  logic        frameDone;
  logic [3:0]  trig;
  logic        unusedHi;

  assign rdy       = {iRdy2, iRdy1};
  assign frameDone = (state == BODY) && link.iTxReady && (idx == LAST_IDX);
  assign unusedHi  = ^{i1COUNTERHi[31:8], i2COUNTERHi[31:8]};

  always_comb begin
    tmo = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      tmo[ch] = TMO_EN && sent[ch] && rdy[ch] && (timer[ch] == TMO_LAST);
    end
  end

  // Snapshot is taken at the IDLE decision and shifted out MSB-first, so input changes never reach the wire.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state         <= IDLE;
      chan          <= 1'b0;
      snap          <= 40'd0;
      idx           <= 3'd0;
      link.oTxValid <= 1'b0;
      link.oTxData  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (iRdy1 && !sent[0]) begin
            snap          <= makeSnapshot(i1COUNTERHi[7:0], i1COUNTER);
            chan          <= 1'b0;
            link.oTxData  <= CHAN1_HDR;
            link.oTxValid <= 1'b1;
            state         <= HDR;
          end else if (iRdy2 && !sent[1]) begin
            snap          <= makeSnapshot(i2COUNTERHi[7:0], i2COUNTER);
            chan          <= 1'b1;
            link.oTxData  <= CHAN2_HDR;
            link.oTxValid <= 1'b1;
            state         <= HDR;
          end
        end
        HDR: begin
          if (link.iTxReady) begin
            link.oTxData <= snap[39:32];
            snap         <= {snap[31:0], 8'h00};
            idx          <= 3'd0;
            state        <= BODY;
          end
        end
        BODY: begin
          if (link.iTxReady) begin
            if (idx == LAST_IDX) begin
              link.oTxValid <= 1'b0;
              state         <= IDLE;
            end else begin
              link.oTxData <= snap[39:32];
              snap         <= {snap[31:0], 8'h00};
              idx          <= idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completing a frame wins over the release clear, so a latch dropped mid-frame re-arms one cycle later.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      sent     <= 2'b00;
      timer[0] <= 32'd0;
      timer[1] <= 32'd0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (frameDone && (chan == 1'(ch))) begin
          sent[ch] <= 1'b1;
        end else if (!rdy[ch] || tmo[ch]) begin
          sent[ch] <= 1'b0;
        end
        if (TMO_EN && sent[ch] && rdy[ch] && !tmo[ch]) begin
          timer[ch] <= timer[ch] + 32'd1;
        end else begin
          timer[ch] <= 32'd0;
        end
      end
    end
  end

  assign trig[0] = link.iRxValid && (link.iRxData == CMD_RST1);
  assign trig[1] = link.iRxValid && (link.iRxData == CMD_RST2);
  assign trig[2] = link.iRxValid && (link.iRxData == CMD_LAT1);
  assign trig[3] = link.iRxValid && (link.iRxData == CMD_LAT2);

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      oBadCmd <= 8'h00;
    end else if (link.iRxValid && (link.iRxData > CMD_LAT2) && (oBadCmd != 8'hFF)) begin
      oBadCmd <= oBadCmd + 8'h01;
    end
  end

  pulse_stretch #(.pPULSE(pPULSE)) uRst1 (.iCLK(iCLK), .iRSTn(iRSTn), .iTrig(trig[0]), .oPulse(oResetLatch1));
  pulse_stretch #(.pPULSE(pPULSE)) uRst2 (.iCLK(iCLK), .iRSTn(iRSTn), .iTrig(trig[1]), .oPulse(oResetLatch2));
  pulse_stretch #(.pPULSE(pPULSE)) uLat1 (.iCLK(iCLK), .iRSTn(iRSTn), .iTrig(trig[2]), .oPulse(oLatch1));
  pulse_stretch #(.pPULSE(pPULSE)) uLat2 (.iCLK(iCLK), .iRSTn(iRSTn), .iTrig(trig[3]), .oPulse(oLatch2));

endmodule

// File: tb/tb_latch_report_link.sv
// Directed bench for latch_report_link: one instance without re-send, one with a 100-cycle re-send timeout.
module tb_latch_report_link;

  typedef struct {
    logic       rxValid;
    logic [7:0] rxData;
    logic [3:0] expPulse;
    logic [7:0] expBad;
  } cmdVec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] c1, c1hi, c2, c2hi;
  logic        rdy1, rdy2;
  logic        txReady;
  logic [7:0]  rxData;
  logic        rxValid;

  logic        rl1A, rl2A, l1A, l2A, rl1B, rl2B, l1B, l2B;
  logic [7:0]  badA, badB;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycleCount = 0;

  cmdVec_t     cmdTab [17];

  latch_report_link_if ifA ();
  latch_report_link_if ifB ();

  assign ifA.iTxReady = txReady;
  assign ifA.iRxData  = rxData;
  assign ifA.iRxValid = rxValid;
  assign ifB.iTxReady = txReady;
  assign ifB.iRxData  = rxData;
  assign ifB.iRxValid = rxValid;

  latch_report_link #(.pPULSE(4), .pTIMEOUT(0)) dutA (
    .iCLK(clk), .iRSTn(rstn), .link(ifA.master),
    .i1COUNTER(c1), .i1COUNTERHi(c1hi), .iRdy1(rdy1),
    .i2COUNTER(c2), .i2COUNTERHi(c2hi), .iRdy2(rdy2),
    .oResetLatch1(rl1A), .oResetLatch2(rl2A), .oLatch1(l1A), .oLatch2(l2A),
    .oBadCmd(badA)
  );

  latch_report_link #(.pPULSE(4), .pTIMEOUT(100)) dutB (
    .iCLK(clk), .iRSTn(rstn), .link(ifB.master),
    .i1COUNTER(c1), .i1COUNTERHi(c1hi), .iRdy1(rdy1),
    .i2COUNTER(c2), .i2COUNTERHi(c2hi), .iRdy2(rdy2),
    .oResetLatch1(rl1B), .oResetLatch2(rl2B), .oLatch1(l1B), .oLatch2(l2B),
    .oBadCmd(badB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input cmdVec_t v);
    rxValid = v.rxValid;
    rxData  = v.rxData;
  endtask

  task automatic doReset();
    rstn    = 1'b0;
    rdy1    = 1'b0;
    rdy2    = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    txReady = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic sendBadBytes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxValid = 1'b1;
      rxData  = 8'h80;
    end
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  // Collects six accepted bytes; in stall mode ready follows 1,0,0,... and the counter inputs change mid-frame.
  task automatic collectFrame(input bit useB, input bit stall, input int budget,
                              output logic [47:0] frame, output int firstCyc, output int lastCyc, output bit ok);
    int n = 0;
    int cyc = 0;
    logic v;
    logic [7:0] d;
    logic [7:0] heldData = 8'h00;
    bit heldValid = 1'b0;
    frame = 48'd0;
    firstCyc = 0;
    lastCyc = 0;
    while (n < 6 && cyc < budget) begin
      @(negedge clk);
      if (stall) begin
        txReady = ((cyc % 3) == 0);
        if (cyc == 4) begin
          c1   = 32'hDEAD_BEEF;
          c1hi = 32'h0000_00EE;
        end
      end
      cyc++;
      #1;
      v = useB ? ifB.oTxValid : ifA.oTxValid;
      d = useB ? ifB.oTxData  : ifA.oTxData;
      if (heldValid) checkOutput("stall hold", {55'd0, v, d}, {55'd0, 1'b1, heldData});
      heldValid = 1'b0;
      if (v && txReady) begin
        frame = {frame[39:0], d};
        n++;
        if (n == 1) firstCyc = cycleCount;
        if (n == 6) lastCyc = cycleCount;
      end else if (v) begin
        heldValid = 1'b1;
        heldData  = d;
      end
    end
    ok = (n == 6);
    txReady = 1'b1;
  endtask

  initial begin
    logic [47:0] frame;
    int firstCyc, lastCyc, first2, last2, quiet, n, guard;
    bit ok;

    // Each row is one cycle of RX input; expectations are sampled one cycle later. Pulse bits: {oLatch2, oLatch1, oResetLatch2, oResetLatch1}.
    cmdTab[0]  = '{1'b1, 8'h00, 4'b0001, 8'd0};
    cmdTab[1]  = '{1'b0, 8'h00, 4'b0001, 8'd0};
    cmdTab[2]  = '{1'b1, 8'h03, 4'b1001, 8'd0};
    cmdTab[3]  = '{1'b1, 8'h7F, 4'b1001, 8'd1};
    cmdTab[4]  = '{1'b0, 8'h00, 4'b1000, 8'd1};
    cmdTab[5]  = '{1'b1, 8'h02, 4'b1100, 8'd1};
    cmdTab[6]  = '{1'b0, 8'h00, 4'b0100, 8'd1};
    cmdTab[7]  = '{1'b1, 8'h02, 4'b0100, 8'd1};
    cmdTab[8]  = '{1'b0, 8'h00, 4'b0100, 8'd1};
    cmdTab[9]  = '{1'b0, 8'h00, 4'b0100, 8'd1};
    cmdTab[10] = '{1'b0, 8'h00, 4'b0100, 8'd1};
    cmdTab[11] = '{1'b0, 8'h00, 4'b0000, 8'd1};
    cmdTab[12] = '{1'b1, 8'h01, 4'b0010, 8'd1};
    cmdTab[13] = '{1'b1, 8'h04, 4'b0010, 8'd2};
    cmdTab[14] = '{1'b1, 8'hFF, 4'b0010, 8'd3};
    cmdTab[15] = '{1'b0, 8'h00, 4'b0010, 8'd3};
    cmdTab[16] = '{1'b0, 8'h00, 4'b0000, 8'd3};

    c1 = 32'd0; c1hi = 32'd0; c2 = 32'd0; c2hi = 32'd0;

    doReset();
    #1;
    checkOutput("reset txValid A", {63'd0, ifA.oTxValid}, 64'd0);
    checkOutput("reset txValid B", {63'd0, ifB.oTxValid}, 64'd0);
    checkOutput("reset pulses A", {60'd0, l2A, l1A, rl2A, rl1A}, 64'd0);
    checkOutput("reset pulses B", {60'd0, l2B, l1B, rl2B, rl1B}, 64'd0);
    checkOutput("reset badCmd A", {56'd0, badA}, 64'd0);
    checkOutput("reset badCmd B", {56'd0, badB}, 64'd0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(cmdTab[i]);
      @(negedge clk);
      checkOutput($sformatf("cmd row %0d pulses", i), {60'd0, l2A, l1A, rl2A, rl1A}, {60'd0, cmdTab[i].expPulse});
      checkOutput($sformatf("cmd row %0d badCmd", i), {56'd0, badA}, {56'd0, cmdTab[i].expBad});
    end
    rxValid = 1'b0;
    sendBadBytes(252);
    checkOutput("badCmd at 255", {56'd0, badA}, 64'hFF);
    sendBadBytes(4);
    checkOutput("badCmd saturated", {56'd0, badA}, 64'hFF);

    doReset();
    c1hi = 32'h0000_00AB; c1 = 32'h1234_5678; rdy1 = 1'b1;
    collectFrame(1'b0, 1'b0, 20, frame, firstCyc, lastCyc, ok);
    checkOutput("report1 complete", {63'd0, ok}, 64'd1);
    checkOutput("report1 bytes", {16'd0, frame}, {16'd0, 48'h00AB_1234_5678});
    checkOutput("report1 consecutive", 64'(lastCyc - firstCyc), 64'd5);
    quiet = 0;
    repeat (150) begin
      @(negedge clk);
      #1;
      if (ifA.oTxValid) quiet++;
    end
    checkOutput("report1 no resend", 64'(quiet), 64'd0);

    doReset();
    c1hi = 32'h0000_00AB; c1 = 32'h1234_5678; rdy1 = 1'b1;
    collectFrame(1'b0, 1'b1, 60, frame, firstCyc, lastCyc, ok);
    checkOutput("backpressure complete", {63'd0, ok}, 64'd1);
    checkOutput("backpressure bytes", {16'd0, frame}, {16'd0, 48'h00AB_1234_5678});

    doReset();
    c1hi = 32'h01; c1 = 32'h0000_0001; c2hi = 32'h02; c2 = 32'h0000_0002;
    rdy1 = 1'b1; rdy2 = 1'b1;
    collectFrame(1'b0, 1'b0, 20, frame, firstCyc, lastCyc, ok);
    checkOutput("simul frame1 bytes", {16'd0, frame}, {16'd0, 48'h0001_0000_0001});
    collectFrame(1'b0, 1'b0, 20, frame, firstCyc, lastCyc, ok);
    checkOutput("simul frame2 complete", {63'd0, ok}, 64'd1);
    checkOutput("simul frame2 bytes", {16'd0, frame}, {16'd0, 48'h0102_0000_0002});
    rdy2 = 1'b0;

    // Timeout decision falls 101 cycles after the last byte; the header is on the wire one cycle later.
    doReset();
    c1hi = 32'h0000_00AB; c1 = 32'h1234_5678; rdy1 = 1'b1;
    collectFrame(1'b1, 1'b0, 20, frame, firstCyc, lastCyc, ok);
    checkOutput("timeout first bytes", {16'd0, frame}, {16'd0, 48'h00AB_1234_5678});
    collectFrame(1'b1, 1'b0, 300, frame, first2, last2, ok);
    checkOutput("timeout resend complete", {63'd0, ok}, 64'd1);
    checkOutput("timeout resend bytes", {16'd0, frame}, {16'd0, 48'h00AB_1234_5678});
    checkOutput("timeout resend delay", 64'(first2 - lastCyc), 64'd102);
    @(negedge clk);
    rdy1 = 1'b0;
    repeat (3) @(negedge clk);
    c1hi = 32'h0000_005A; c1 = 32'hCAFE_0001; rdy1 = 1'b1;
    collectFrame(1'b1, 1'b0, 20, frame, firstCyc, lastCyc, ok);
    checkOutput("rearm bytes", {16'd0, frame}, {16'd0, 48'h005A_CAFE_0001});

    doReset();
    c1hi = 32'h0000_00AB; c1 = 32'h1234_5678; rdy1 = 1'b1;
    n = 0;
    guard = 0;
    while (n < 3 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
      if (ifA.oTxValid && txReady) n++;
    end
    checkOutput("midreset reached byte 3", 64'(n), 64'd3);
    rxValid = 1'b1; rxData = 8'h02;
    @(negedge clk);
    rxValid = 1'b0;
    rstn = 1'b0;
    #1;
    checkOutput("midreset pulse before reset", {63'd0, l1A}, 64'd1);
    @(negedge clk);
    #1;
    checkOutput("midreset txValid", {63'd0, ifA.oTxValid}, 64'd0);
    checkOutput("midreset pulses", {60'd0, l2A, l1A, rl2A, rl1A}, 64'd0);
    rstn = 1'b1;
    collectFrame(1'b0, 1'b0, 20, frame, firstCyc, lastCyc, ok);
    checkOutput("midreset restart bytes", {16'd0, frame}, {16'd0, 48'h00AB_1234_5678});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
